// File: rtl/multiword_add_seq_pkg.sv
// rtl/multiword_add_seq_pkg.sv - shared constants, FSM state type and counter sizing for multiword_add_seq
package multiword_add_seq_pkg;

    localparam int ADD_W = 16;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Word counter must hold 0..words-1; keep at least one bit for words == 1.
    function automatic int cnt_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// rtl/multiword_add_seq_if.sv - operand/sum stream bundle for multiword_add_seq (ovf present under MWADD_OVF_EN)
interface multiword_add_seq_if;
    import multiword_add_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [ADD_W-1:0] a_word;
    logic [ADD_W-1:0] b_word;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [ADD_W-1:0] sum_word;
    logic             out_last;
    logic             cout;
    logic             busy;
`ifdef MWADD_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a_word, b_word, cin, out_ready,
        input  in_ready, out_valid, sum_word, out_last, cout, busy, ovf
    );
    modport slave (
        input  in_valid, a_word, b_word, cin, out_ready,
        output in_ready, out_valid, sum_word, out_last, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a_word, b_word, cin, out_ready,
        input  in_ready, out_valid, sum_word, out_last, cout, busy
    );
    modport slave (
        input  in_valid, a_word, b_word, cin, out_ready,
        output in_ready, out_valid, sum_word, out_last, cout, busy
    );
`endif

endinterface

// File: rtl/multiword_add_seq_ripple_16.sv
// rtl/multiword_add_seq_ripple_16.sv - 16-bit ripple-carry adder word slice
module ripple_16
    import multiword_add_seq_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    logic [ADD_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < ADD_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[ADD_W];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - word-serial multi-precision adder with registered sum stage
// Optional two's-complement overflow output on the last word when MWADD_OVF_EN is defined.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    multiword_add_seq_if.slave bus
);

    localparam int               CNT_W    = cnt_w(WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [ADD_W-1:0] sum_q, sum_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             is_last;
    logic             add_cin;
    logic [ADD_W-1:0] add_sum;
    logic             add_cout;

    assign bus.in_ready = !rst && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_last      = (cnt_q == LAST_CNT);

    ripple_16 u_add (
        .a    (bus.a_word),
        .b    (bus.b_word),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_FIRST: if (WORDS > 1) state_d = ST_RUN;
                ST_RUN:   if (is_last)   state_d = ST_FIRST;
                default:                 state_d = ST_FIRST;
            endcase
        end
    end

    // The carry register is never consulted on word 0, so nothing leaks between operations.
    always_comb begin
        add_cin = (state_q == ST_FIRST) ? bus.cin : carry_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        last_d  = last_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            cnt_d   = is_last ? '0 : cnt_q + 1'b1;
            carry_d = add_cout;
            sum_d   = add_sum;
            valid_d = 1'b1;
            last_d  = is_last;
            cout_d  = is_last && add_cout;
            ovf_d   = is_last && (bus.a_word[ADD_W-1] == bus.b_word[ADD_W-1])
                              && (add_sum[ADD_W-1] != bus.a_word[ADD_W-1]);
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.sum_word  = sum_q;
    assign bus.out_last  = last_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = (cnt_q != '0) || valid_q;

`ifdef MWADD_OVF_EN
    assign bus.ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequential multi-precision adder that streams two operands of WORDS×16 bits, least-significant word first, through the existing 16-bit ripple-carry adder, one word per cycle. It sits directly upstream of that adder: it feeds its a/b/cin inputs and consumes its sum/cout. A registered carry chains consecutive words, and a one-entry registered output stage presents sum words with a valid/ready handshake.

## Interface
- WORDS, 4, 16-bit words per operand; legal range 1..256.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a_word/b_word (and cin on first word) valid.
- in_ready  out  1  block accepts a word this cycle.
- a_word  in  16  operand A word.
- b_word  in  16  operand B word.
- cin  in  1  carry-in; sampled only on the first word of an operation.
- out_valid  out  1  sum_word valid.
- out_ready  in  1  consumer takes sum_word this cycle.
- sum_word  out  16  sum word.
- out_last  out  1  sum_word is the final (most-significant) word.
- cout  out  1  final carry-out; meaningful only when out_valid && out_last, else 0.
- busy  out  1  an operation is in progress (word_cnt != 0 or out_valid).

## Operation
- Accept = in_valid && in_ready. in_ready = !rst && (!out_valid || out_ready).
- FSM states:
  - FIRST: next accepted word is word 0; adder carry-in = cin.
  - RUN: adder carry-in = carry_reg.
- FIRST→RUN on accept when WORDS>1. RUN→FIRST on accept of word WORDS-1. With WORDS=1, stay in FIRST.
- On accept:
  - sum_word ← adder sum; carry_reg ← adder cout; out_valid ← 1.
  - out_last ← (word_cnt == WORDS-1); cout ← adder cout if last, else 0.
  - word_cnt increments and wraps to 0 after WORDS-1.
- Output register:
  - No accept, out_ready=1: out_valid ← 0, out_last ← 0, cout ← 0.
  - No accept, out_ready=0: all outputs hold stable.
- Width rules: 16-bit adds, modulo 2^16 per word. Carry propagates only within one operation; carry_reg is never used on word 0.
- Reset values: out_valid 0, sum_word 0, out_last 0, cout 0, busy 0, carry_reg 0, word_cnt 0, state FIRST, in_ready 0 during rst.
- Reset mid-operation discards partial results and any pending output word. The next accepted word is word 0 and uses cin.

## Timing
- Latency: accept in cycle N → out_valid with that word's sum in cycle N+1.
- Throughput: one word per cycle while out_ready stays high.
- Back-to-back operations: word 0 of operation k+1 may be accepted in the cycle after the last word of operation k, with no bubble.
- Simultaneous output handoff and new accept in the same cycle: the register reloads, and out_valid stays 1.
- in_ready depends combinationally on out_valid and out_ready. There is no combinational path from in_valid to out_valid.

## Configuration
- MWADD_OVF_EN defined:
  - Adds output port ovf (out, 1): two's-complement overflow of the full WORDS×16-bit add.
  - ovf = (a_msb == b_msb) && (sum_msb != a_msb) on the last word; registered alongside cout.
  - ovf is 0 when not out_last, and 0 at reset.
- MWADD_OVF_EN undefined: ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - the word-width constant ADD_W = 16;
  - the FSM state typedef (FIRST, RUN);
  - the word-counter width as a function of WORDS.
- One sub-module: ripple_16, instantiated once and unchanged (a, b, cin → sum, cout). The carry mux, counter, FSM and output register live in multiword_add_seq.

## Test plan
- Carry across words: WORDS=2, cin=0. Words (0xFFFF, 0x0001) + (0x0001, 0x0000) → sum_word 0x0000 then 0x0002; out_last on 2nd word; cout=0.
- Full-width carry-out: WORDS=2, cin=1. (0xFFFF, 0xFFFF) + (0x0000, 0x0000) → 0x0000, 0x0000; cout=1 with out_last.
- Backpressure: hold out_ready=0 after the first accept → in_ready=0, and sum_word/out_valid hold for 5 cycles. Release → words delivered in order with no loss or duplication.
- Reset mid-operation:
  - Accept word 0 of 0xFFFF+0x0001 (carry_reg=1), then pulse rst.
  - Next operation 0x0001+0x0001, cin=0 → first sum_word 0x0002; out_valid=0 during and right after reset.
- Back-to-back with no carry leak: op1 ends with cout=1; op2 (0x0000, 0x0000)+(0x0000, 0x0000), cin=0 accepted the next cycle → sums 0x0000, 0x0000; cout=0.
- MWADD_OVF_EN: WORDS=1, 0x7FFF+0x0001 → sum 0x8000, ovf=1, cout=0. With 0xFFFF+0x0001 → sum 0x0000, ovf=0, cout=1.
